hopfield_core_param: RTL and testbench
======================================

Name: hopfield_core_param

Overview:
Parametrised next-generation Hopfield associative memory: N bipolar neurons, symmetric signed weight matrix with zero diagonal, on-chip Hebbian learning and iterative recall.
- Recall is a sequential per-neuron update using a serial multiply-accumulate.
- Includes convergence detection, a sweep limit, a registered activity popcount and a weight debug read port.
- Sits between the tt_um top-level IO mapping and the status/spike outputs.

Parameters:
- N, 7, number of neurons (2..16).
- WW, 4, signed weight width; weights saturate to ±(2^(WW-1)-1).
- MAX_SWEEPS, 4, recall sweep limit (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clear_weights  in  1  pulse; zero all weights
- start_learn  in  1  pulse; Hebbian-store pattern_in
- start_recall  in  1  pulse; recall from probe pattern_in
- pattern_in  in  N  bit=1 → +1, bit=0 → −1; sampled on the accepted start cycle only
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at the end of every operation
- converged  out  1  valid from done; held until the next start
- state_out  out  N  current neuron states
- activity  out  $clog2(N+1)  registered popcount of state_out
- sweep_count  out  4  sweeps used by the last recall
- dbg_i, dbg_j  in  $clog2(N) each  weight read address
- dbg_w  out  WW  combinational read of w[dbg_i][dbg_j]; signed

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all weights 0, state_out 0, activity 0, sweep_count 0, converged 0, busy 0, done 0, FSM IDLE. Reset mid-operation aborts immediately.
- FSM states: IDLE, CLEAR, LEARN, ACC, UPD, DONE.
- Start acceptance: start pulses are accepted only in IDLE and ignored otherwise. Priority when simultaneous: clear_weights > start_learn > start_recall.
- CLEAR: 1 cycle, zeros all weights, then DONE.
- LEARN:
  - Latches the pattern.
  - Iterates pairs (i<j) in row-major order, one pair per cycle: N(N-1)/2 cycles.
  - Each cycle: w[i][j] and w[j][i] += s_i·s_j, saturating, never wrapping. Diagonal stays 0.
  - Then DONE, where converged = 0.
- Recall:
  - Load state_out ← pattern_in and clear the change flag.
  - For i = 0..N-1:
    - ACC: N cycles, j = 0..N-1, acc += s_j ? w[i][j] : −w[i][j].
    - UPD: 1 cycle; h>0 → s_i = 1; h<0 → s_i = 0; h==0 → unchanged; a change sets the change flag.
  - Accumulator width is WW+$clog2(N)+1, signed, with no overflow possible.
  - Sweep length is N(N+1) cycles; sweep_count increments at the end of each sweep.
  - Sweep ends with no change → converged = 1, go to DONE.
  - Sweep ends with a change and sweep_count == MAX_SWEEPS → converged = 0, go to DONE.
  - Otherwise clear the change flag and start the next sweep.
- Timing:
  - DONE lasts 1 cycle with done = 1, then IDLE.
  - busy is high from the cycle after acceptance through DONE.
  - state_out changes only at recall load and at UPD.
  - activity = popcount(state_out) from the previous cycle (1-cycle latency).

Decomposition:
- Package hopfield_pkg:
  - FSM state enum.
  - Function for the saturation bound WMAX = 2^(WW-1)-1.
  - Width helper for the accumulator.
- Sub-module hopfield_weight_bank:
  - Owns the N×N weight registers.
  - Symmetric saturating ±1 update port.
  - Clear.
  - Two combinational read ports: MAC row read and debug read.

Test Plan:
1. Assert rst with busy high mid-LEARN → busy/done/state_out/activity all 0 immediately; all dbg_w reads 0.
2. N=7, WW=4: clear, then learn 7'b1010101 → done pulses 22 cycles after acceptance; w[0][1] = −1, w[0][2] = +1, w[3][3] = 0, w[1][0] = w[0][1].
3. After test 2, recall probe 7'b1010100 → state_out = 7'b1010101, converged = 1, sweep_count = 2, activity = 4 one cycle after the final update, done after 2·56 + 1 cycles of busy.
4. Learn 7'b1010101 ten times → w[0][2] = +7, w[0][1] = −7 (no wrap); recall of 7'b0010101 still yields 7'b1010101.
5. MAX_SWEEPS = 1, same probe as test 3 → done with converged = 0, sweep_count = 1, state_out = 7'b1010101. With all-zero weights, any probe → unchanged, converged = 1, sweep_count = 1.
6. Pulse start_recall while busy → ignored. Pulse clear_weights and start_learn together in IDLE → only CLEAR runs (done after 2 cycles), weights 0.

Source files
------------

// File: rtl/hopfield_pkg.sv
// Shared types and sizing helpers for the Hopfield associative memory core.
package hopfield_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEARN,
        ACC,
        UPD,
        DONE
    } state_t;

    // Saturation bound keeps weights symmetric around zero: +/-(2^(WW-1)-1).
    function automatic int wmax(input int ww);
        return (1 << (ww - 1)) - 1;
    endfunction

    function automatic int acc_width(input int ww, input int n);
        return ww + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/hopfield_core_param_if.sv
// Control, status and debug-read signals of the Hopfield core.
interface hopfield_core_param_if #(
    parameter int N  = 7,
    parameter int WW = 4
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic                 clear_weights;
    logic                 start_learn;
    logic                 start_recall;
    logic [N-1:0]         pattern_in;
    logic                 busy;
    logic                 done;
    logic                 converged;
    logic [N-1:0]         state_out;
    logic [CW-1:0]        activity;
    logic [3:0]           sweep_count;
    logic [IW-1:0]        dbg_i;
    logic [IW-1:0]        dbg_j;
    logic signed [WW-1:0] dbg_w;

    modport master (
        output clear_weights, start_learn, start_recall, pattern_in, dbg_i, dbg_j,
        input  busy, done, converged, state_out, activity, sweep_count, dbg_w
    );

    modport slave (
        input  clear_weights, start_learn, start_recall, pattern_in, dbg_i, dbg_j,
        output busy, done, converged, state_out, activity, sweep_count, dbg_w
    );

endinterface

// File: rtl/hopfield_weight_bank.sv
// N x N signed weight registers with symmetric saturating +/-1 update,
// clear, and two combinational read ports (MAC and debug).
module hopfield_weight_bank
    import hopfield_pkg::*;
#(
    parameter int N  = 7,
    parameter int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 upd_en,
    input  logic [IW-1:0]        upd_i,
    input  logic [IW-1:0]        upd_j,
    input  logic                 upd_inc,
    input  logic [IW-1:0]        mac_i,
    input  logic [IW-1:0]        mac_j,
    output logic signed [WW-1:0] mac_w,
    input  logic [IW-1:0]        dbg_i,
    input  logic [IW-1:0]        dbg_j,
    output logic signed [WW-1:0] dbg_w
);
    localparam logic signed [WW-1:0] WMAX_V = WW'(wmax(WW));
    localparam logic signed [WW-1:0] ONE    = WW'(1);

    logic signed [WW-1:0] w [N][N];
    logic signed [WW-1:0] w_cur;
    logic                 dbg_in_range;

    assign w_cur = w[upd_i][upd_j];

    // Only i<j pairs are ever addressed, so the diagonal stays at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < N; a++)
                for (int b = 0; b < N; b++)
                    w[a][b] <= '0;
        end else if (clear) begin
            for (int a = 0; a < N; a++)
                for (int b = 0; b < N; b++)
                    w[a][b] <= '0;
        end else if (upd_en) begin
            if (upd_inc && (w_cur != WMAX_V)) begin
                w[upd_i][upd_j] <= w_cur + ONE;
                w[upd_j][upd_i] <= w_cur + ONE;
            end else if (!upd_inc && (w_cur != -WMAX_V)) begin
                w[upd_i][upd_j] <= w_cur - ONE;
                w[upd_j][upd_i] <= w_cur - ONE;
            end
        end
    end

    assign mac_w = w[mac_i][mac_j];

    assign dbg_in_range = ({1'b0, dbg_i} < (IW + 1)'(N)) && ({1'b0, dbg_j} < (IW + 1)'(N));
    assign dbg_w        = dbg_in_range ? w[dbg_i][dbg_j] : '0;

endmodule

// File: rtl/hopfield_core_param.sv
// Hopfield associative memory: Hebbian learning and sequential recall
// with a serial MAC, convergence detection and a sweep limit.
//
// state | meaning
// IDLE  | waiting for clear_weights / start_learn / start_recall
// CLEAR | zero all weights (1 cycle)
// LEARN | one i<j pair per cycle, symmetric saturating update
// ACC   | accumulate field of neuron i over j = 0..N-1
// UPD   | threshold field into s_i, end-of-sweep decision
// DONE  | one-cycle done pulse
module hopfield_core_param
    import hopfield_pkg::*;
#(
    parameter int N          = 7,
    parameter int WW         = 4,
    parameter int MAX_SWEEPS = 4
) (
    input logic                   clk,
    input logic                   rst,
    hopfield_core_param_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int AW = acc_width(WW, N);

    state_t               state, state_nxt;
    logic [IW-1:0]        idx_i, idx_j;
    logic [N-1:0]         pat;
    logic [N-1:0]         s;
    logic signed [AW-1:0] acc;
    logic                 changed;
    logic [3:0]           sweeps;
    logic                 conv;
    logic [CW-1:0]        act;

    logic                 last_j, last_i, last_pair;
    logic                 h_pos, h_neg, flip, any_change, sweep_limit;
    logic signed [WW-1:0] mac_w;
    logic signed [AW-1:0] w_ext, term;

    hopfield_weight_bank #(.N(N), .WW(WW)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == CLEAR),
        .upd_en  (state == LEARN),
        .upd_i   (idx_i),
        .upd_j   (idx_j),
        .upd_inc (pat[idx_i] ~^ pat[idx_j]),
        .mac_i   (idx_i),
        .mac_j   (idx_j),
        .mac_w   (mac_w),
        .dbg_i   (bus.dbg_i),
        .dbg_j   (bus.dbg_j),
        .dbg_w   (bus.dbg_w)
    );

    assign last_j    = (idx_j == IW'(N - 1));
    assign last_i    = (idx_i == IW'(N - 1));
    assign last_pair = (idx_i == IW'(N - 2)) && last_j;

    assign w_ext = {{(AW - WW){mac_w[WW-1]}}, mac_w};
    assign term  = s[idx_j] ? w_ext : -w_ext;

    // acc holds the complete field of neuron idx_i while in UPD.
    assign h_neg       = acc[AW-1];
    assign h_pos       = (acc != '0) && !acc[AW-1];
    assign flip        = (h_pos && !s[idx_i]) || (h_neg && s[idx_i]);
    assign any_change  = changed | flip;
    assign sweep_limit = ((sweeps + 4'd1) == 4'(MAX_SWEEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.clear_weights)     state_nxt = CLEAR;
                else if (bus.start_learn)  state_nxt = LEARN;
                else if (bus.start_recall) state_nxt = ACC;
            end
            CLEAR: state_nxt = DONE;
            LEARN: if (last_pair) state_nxt = DONE;
            ACC:   if (last_j) state_nxt = UPD;
            UPD: begin
                if (last_i && (!any_change || sweep_limit)) state_nxt = DONE;
                else                                        state_nxt = ACC;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_i   <= '0;
            idx_j   <= '0;
            pat     <= '0;
            s       <= '0;
            acc     <= '0;
            changed <= 1'b0;
            sweeps  <= '0;
            conv    <= 1'b0;
            act     <= '0;
        end else begin
            act <= CW'($countones(s));
            case (state)
                IDLE: begin
                    if (bus.clear_weights) begin
                        conv <= 1'b0;
                    end else if (bus.start_learn) begin
                        pat   <= bus.pattern_in;
                        idx_i <= '0;
                        idx_j <= IW'(1);
                        conv  <= 1'b0;
                    end else if (bus.start_recall) begin
                        s       <= bus.pattern_in;
                        idx_i   <= '0;
                        idx_j   <= '0;
                        changed <= 1'b0;
                        sweeps  <= '0;
                        conv    <= 1'b0;
                    end
                end
                LEARN: begin
                    if (last_j) begin
                        idx_i <= idx_i + IW'(1);
                        idx_j <= idx_i + IW'(2);
                    end else begin
                        idx_j <= idx_j + IW'(1);
                    end
                end
                ACC: begin
                    acc   <= ((idx_j == '0) ? '0 : acc) + term;
                    idx_j <= last_j ? '0 : idx_j + IW'(1);
                end
                UPD: begin
                    if (h_pos)      s[idx_i] <= 1'b1;
                    else if (h_neg) s[idx_i] <= 1'b0;
                    changed <= any_change;
                    if (last_i) begin
                        idx_i  <= '0;
                        sweeps <= sweeps + 4'd1;
                        if (!any_change)      conv    <= 1'b1;
                        else if (sweep_limit) conv    <= 1'b0;
                        else                  changed <= 1'b0;
                    end else begin
                        idx_i <= idx_i + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.converged   = conv;
    assign bus.state_out   = s;
    assign bus.activity    = act;
    assign bus.sweep_count = sweeps;

endmodule

// File: tb/tb_hopfield_core_param.sv
// Randomised and directed bench for hopfield_core_param against a loop-level
// Hopfield model; a second instance with a one-sweep limit shadows every op.
module tb_hopfield_core_param;
    import hopfield_pkg::*;

    localparam int N  = 7;
    localparam int WW = 4;
    localparam int SWEEP = N * (N + 1);
    localparam int WM = 7;

    logic clk;
    logic rst;

    hopfield_core_param_if #(.N(N), .WW(WW)) bus0 ();
    hopfield_core_param_if #(.N(N), .WW(WW)) bus1 ();

    hopfield_core_param #(.N(N), .WW(WW), .MAX_SWEEPS(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    hopfield_core_param #(.N(N), .WW(WW), .MAX_SWEEPS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.clear_weights = bus0.clear_weights;
    assign bus1.start_learn   = bus0.start_learn;
    assign bus1.start_recall  = bus0.start_recall;
    assign bus1.pattern_in    = bus0.pattern_in;
    assign bus1.dbg_i         = bus0.dbg_i;
    assign bus1.dbg_j         = bus0.dbg_j;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int mw [N][N];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mw[i][j] = 0;
    endtask

    task automatic model_learn(input logic [N-1:0] p);
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                int v;
                v = mw[i][j] + ((p[i] == p[j]) ? 1 : -1);
                if (v > WM) v = WM;
                if (v < -WM) v = -WM;
                mw[i][j] = v;
                mw[j][i] = v;
            end
    endtask

    task automatic model_recall(input logic [N-1:0] probe, input int maxs,
                                output logic [N-1:0] s, output int conv, output int sw);
        s = probe;
        sw = 0;
        conv = 0;
        forever begin
            bit ch;
            ch = 0;
            for (int i = 0; i < N; i++) begin
                int h;
                h = 0;
                for (int j = 0; j < N; j++) h += s[j] ? mw[i][j] : -mw[i][j];
                if (h > 0 && !s[i]) begin s[i] = 1'b1; ch = 1; end
                if (h < 0 && s[i])  begin s[i] = 1'b0; ch = 1; end
            end
            sw++;
            if (!ch) begin conv = 1; break; end
            if (sw == maxs) begin conv = 0; break; end
        end
    endtask

    // kind: 0 clear, 1 learn, 2 recall, 3 clear+learn together
    task automatic start_op(input int kind, input logic [N-1:0] p);
        @(negedge clk);
        bus0.clear_weights = (kind == 0 || kind == 3);
        bus0.start_learn   = (kind == 1 || kind == 3);
        bus0.start_recall  = (kind == 2);
        bus0.pattern_in    = p;
        @(negedge clk);
        bus0.clear_weights = 1'b0;
        bus0.start_learn   = 1'b0;
        bus0.start_recall  = 1'b0;
        bus0.pattern_in    = $urandom();
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!bus0.done && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", int'(bus0.done), 1);
    endtask

    task automatic read_w(input int i, input int j, output int v);
        bus0.dbg_i = 3'(i);
        bus0.dbg_j = 3'(j);
        #1;
        v = int'(bus0.dbg_w);
    endtask

    task automatic check_weights(input string tag);
        int v;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                read_w(i, j, v);
                chk(tag, v, mw[i][j]);
            end
    endtask

    task automatic run_clear();
        int lat;
        model_reset();
        start_op(0, '0);
        wait_done(1, lat);
        chk("clear_lat", lat, 2);
    endtask

    task automatic run_learn(input logic [N-1:0] p);
        int lat;
        model_learn(p);
        start_op(1, p);
        chk("learn_busy", int'(bus0.busy), 1);
        wait_done(1, lat);
        chk("learn_lat", lat, N * (N - 1) / 2 + 1);
        chk("learn_conv", int'(bus0.converged), 0);
    endtask

    task automatic run_recall(input logic [N-1:0] probe);
        logic [N-1:0] es, es1;
        int ec, esw, ec1, esw1, lat;
        model_recall(probe, 4, es, ec, esw);
        model_recall(probe, 1, es1, ec1, esw1);
        start_op(2, probe);
        wait_done(1, lat);
        chk("rc_lat", lat, esw * SWEEP + 1);
        chk("rc_state", int'(bus0.state_out), int'(es));
        chk("rc_conv", int'(bus0.converged), ec);
        chk("rc_sweeps", int'(bus0.sweep_count), esw);
        @(negedge clk);
        chk("rc_busy_idle", int'(bus0.busy), 0);
        chk("rc_activity", int'(bus0.activity), $countones(es));
        chk("rc1_state", int'(bus1.state_out), int'(es1));
        chk("rc1_conv", int'(bus1.converged), ec1);
        chk("rc1_sweeps", int'(bus1.sweep_count), esw1);
    endtask

    initial begin
        int v, lat;
        logic [N-1:0] p, es;
        int ec, esw;

        rst = 1'b1;
        bus0.clear_weights = 1'b0;
        bus0.start_learn   = 1'b0;
        bus0.start_recall  = 1'b0;
        bus0.pattern_in    = '0;
        bus0.dbg_i         = '0;
        bus0.dbg_j         = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_done", int'(bus0.done), 0);
        chk("rst_state", int'(bus0.state_out), 0);
        chk("rst_activity", int'(bus0.activity), 0);
        chk("rst_sweeps", int'(bus0.sweep_count), 0);
        chk("rst_conv", int'(bus0.converged), 0);
        rst = 1'b0;

        // zero weights: probe is a fixed point
        run_recall(7'b0110011);
        chk("zero_w_state", int'(bus0.state_out), 'b0110011);
        chk("zero_w_sweeps", int'(bus0.sweep_count), 1);

        // reset in the middle of a learn
        start_op(1, 7'b1010101);
        repeat (4) @(negedge clk);
        chk("midlearn_busy", int'(bus0.busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus0.busy), 0);
        chk("abort_done", int'(bus0.done), 0);
        chk("abort_state", int'(bus0.state_out), 0);
        chk("abort_activity", int'(bus0.activity), 0);
        model_reset();
        check_weights("abort_w");
        @(negedge clk);
        rst = 1'b0;

        // single stored pattern
        run_clear();
        run_learn(7'b1010101);
        read_w(0, 1, v); chk("w01", v, -1);
        read_w(0, 2, v); chk("w02", v, 1);
        read_w(3, 3, v); chk("w33", v, 0);
        read_w(1, 0, v); chk("w10", v, -1);
        check_weights("learn1_w");

        run_recall(7'b1010100);
        chk("t3_state", int'(bus0.state_out), 'b1010101);
        chk("t3_conv", int'(bus0.converged), 1);
        chk("t3_sweeps", int'(bus0.sweep_count), 2);
        chk("t3_activity", int'(bus0.activity), 4);
        chk("t3_lim_conv", int'(bus1.converged), 0);
        chk("t3_lim_sweeps", int'(bus1.sweep_count), 1);
        chk("t3_lim_state", int'(bus1.state_out), 'b1010101);

        // saturation
        repeat (10) run_learn(7'b1010101);
        read_w(0, 2, v); chk("sat_w02", v, 7);
        read_w(0, 1, v); chk("sat_w01", v, -7);
        check_weights("sat_w");
        run_recall(7'b0010101);
        chk("sat_recall", int'(bus0.state_out), 'b1010101);

        // starts while busy are ignored
        p = 7'b0110100;
        model_recall(p, 4, es, ec, esw);
        start_op(2, p);
        repeat (9) @(negedge clk);
        bus0.start_recall = 1'b1;
        bus0.start_learn  = 1'b1;
        bus0.pattern_in   = ~p;
        @(negedge clk);
        bus0.start_recall = 1'b0;
        bus0.start_learn  = 1'b0;
        wait_done(11, lat);
        chk("ign_lat", lat, esw * SWEEP + 1);
        chk("ign_state", int'(bus0.state_out), int'(es));
        @(negedge clk);
        check_weights("ign_w");

        // clear beats learn when both pulse together
        model_reset();
        start_op(3, 7'b1100110);
        wait_done(1, lat);
        chk("prio_lat", lat, 2);
        @(negedge clk);
        check_weights("prio_w");

        // randomised rounds
        for (int r = 0; r < 5; r++) begin
            logic [N-1:0] stored;
            int k;
            run_clear();
            k = $urandom_range(1, 3);
            stored = '0;
            for (int q = 0; q < k; q++) begin
                stored = N'($urandom());
                run_learn(stored);
            end
            check_weights("rnd_w");
            for (int t = 0; t < 3; t++) begin
                if (t == 0) p = stored ^ (N'(1) << $urandom_range(0, N - 1));
                else        p = N'($urandom());
                run_recall(p);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
